// File: rtl/warp_ctrl_pkg.sv
// Shared types and constants for the warp readiness controller.
// Slot lifecycle encoding, issue-class bit positions and a width helper.
package warp_ctrl_pkg;

  typedef enum logic [1:0] {
    FREE     = 2'd0,
    ACTIVE   = 2'd1,
    BAR_WAIT = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  localparam int CLS_MEM  = 0;
  localparam int CLS_BAR  = 1;
  localparam int CLS_EXIT = 2;
  localparam int NCLS     = 3;

  localparam int DEF_WARPS     = 8;
  localparam int DEF_MAXOUT    = 4;
  localparam int DEF_ISSUE_GAP = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/warp_slot.sv
// One warp slot: lifecycle FSM, outstanding-memory counter and issue cooldown.
// Strobes are pre-validated by the parent; ready is decoded from registers only.
module warp_slot
  import warp_ctrl_pkg::*;
#(
  parameter int MAXOUT    = DEF_MAXOUT,
  parameter int OCW       = 3,
  parameter int ISSUE_GAP = DEF_ISSUE_GAP
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_launch,
  input  logic           i_issue,
  input  logic           i_exit,
  input  logic           i_bar,
  input  logic           i_mem,
  input  logic           i_mem_done,
  input  logic           i_release,
  output logic           o_ready,
  output logic [1:0]     o_state,
  output logic [OCW-1:0] o_outcnt
);

  localparam int CW = (ISSUE_GAP < 1) ? 1 : clog2(ISSUE_GAP + 1);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [OCW-1:0] r_outcnt;
  logic [CW-1:0]  r_cool;
  logic           w_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FREE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FREE:     if (i_launch) w_state_nxt = ACTIVE;
      ACTIVE: begin
        if (i_issue && i_exit)     w_state_nxt = DRAIN;
        else if (i_issue && i_bar) w_state_nxt = BAR_WAIT;
      end
      BAR_WAIT: if (i_release) w_state_nxt = ACTIVE;
      // Uses the registered count, so a slot spends at least one cycle here.
      DRAIN:    if (r_outcnt == '0) w_state_nxt = FREE;
      default:  w_state_nxt = FREE;
    endcase
  end

  assign w_inc = i_issue && i_mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outcnt <= '0;
      r_cool   <= '0;
    end else if (i_launch) begin
      r_outcnt <= '0;
      r_cool   <= '0;
    end else begin
      if (w_inc && !i_mem_done)      r_outcnt <= r_outcnt + OCW'(1);
      else if (!w_inc && i_mem_done) r_outcnt <= r_outcnt - OCW'(1);
      if (i_issue)                   r_cool <= CW'(ISSUE_GAP);
      else if (r_cool != '0)         r_cool <= r_cool - CW'(1);
    end
  end

  assign o_ready  = (r_state == ACTIVE) && (r_outcnt < OCW'(MAXOUT)) && (r_cool == '0);
  assign o_state  = r_state;
  assign o_outcnt = r_outcnt;

endmodule

// File: rtl/warp_ready_ctrl.sv
// Per-warp readiness for the round-robin scheduler: event decode, barrier detect, errors.
// ready_mask and bar_release depend on registered slot state only, closing the issue loop.
module warp_ready_ctrl
  import warp_ctrl_pkg::*;
#(
  parameter int WARPS     = DEF_WARPS,
  parameter int IDW       = clog2(WARPS),
  parameter int MAXOUT    = DEF_MAXOUT,
  parameter int OCW       = clog2(MAXOUT + 1),
  parameter int ISSUE_GAP = DEF_ISSUE_GAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             launch_valid,
  input  logic [IDW-1:0]   launch_id,
  output logic             launch_ready,
  input  logic [WARPS-1:0] issue_onehot,
  input  logic             issue_valid,
  input  logic             issue_accept,
  input  logic             issue_is_mem,
  input  logic             issue_is_bar,
  input  logic             issue_is_exit,
  input  logic             mem_done_valid,
  input  logic [IDW-1:0]   mem_done_id,
  output logic [WARPS-1:0] ready_mask,
  output logic [WARPS-1:0] active_mask,
  output logic             bar_release,
  output logic             all_done,
  output logic             err_protocol
);

  logic [1:0]       w_state  [WARPS];
  logic [OCW-1:0]   w_outcnt [WARPS];
  logic [WARPS-1:0] w_part, w_wait, w_slot_launch, w_slot_issue, w_slot_md;
  logic [NCLS-1:0]  w_cls;
  logic             w_issue_evt, w_onehot, w_hit_ready, w_issue_ok, w_multi_cls;
  logic             w_exit, w_bar, w_mem, w_md_ok, w_launch_fire, w_bar_rel, w_err_set;
  logic             r_err;

  assign w_cls       = {issue_is_exit, issue_is_bar, issue_is_mem};
  assign w_issue_evt = issue_valid && issue_accept;
  assign w_onehot    = (issue_onehot != '0) &&
                       ((issue_onehot & (issue_onehot - WARPS'(1))) == '0);
  assign w_hit_ready = (issue_onehot & ready_mask) != '0;
  assign w_issue_ok  = w_issue_evt && w_onehot && w_hit_ready;
  assign w_multi_cls = (w_cls[CLS_EXIT] && w_cls[CLS_BAR]) ||
                       (w_cls[CLS_EXIT] && w_cls[CLS_MEM]) ||
                       (w_cls[CLS_BAR]  && w_cls[CLS_MEM]);

  // exit > bar > mem; an issue with no class bit is a plain ALU op.
  assign w_exit = w_cls[CLS_EXIT];
  assign w_bar  = w_cls[CLS_BAR] && !w_cls[CLS_EXIT];
  assign w_mem  = w_cls[CLS_MEM] && !w_cls[CLS_BAR] && !w_cls[CLS_EXIT];

  assign w_md_ok       = mem_done_valid && (w_outcnt[mem_done_id] != '0);
  assign launch_ready  = (w_state[launch_id] == FREE);
  assign w_launch_fire = launch_valid && launch_ready;

  assign w_err_set = (w_issue_evt && (!w_onehot || !w_hit_ready || w_multi_cls)) ||
                     (mem_done_valid && !w_md_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
  end

  for (genvar g = 0; g < WARPS; g++) begin : g_slot
    assign w_slot_launch[g] = w_launch_fire && (launch_id == IDW'(g));
    assign w_slot_issue[g]  = w_issue_ok && issue_onehot[g];
    assign w_slot_md[g]     = w_md_ok && (mem_done_id == IDW'(g));

    warp_slot #(
      .MAXOUT    (MAXOUT),
      .OCW       (OCW),
      .ISSUE_GAP (ISSUE_GAP)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .i_launch   (w_slot_launch[g]),
      .i_issue    (w_slot_issue[g]),
      .i_exit     (w_exit),
      .i_bar      (w_bar),
      .i_mem      (w_mem),
      .i_mem_done (w_slot_md[g]),
      .i_release  (w_bar_rel),
      .o_ready    (ready_mask[g]),
      .o_state    (w_state[g]),
      .o_outcnt   (w_outcnt[g])
    );

    assign active_mask[g] = (w_state[g] != FREE);
    assign w_part[g]      = (w_state[g] == ACTIVE) || (w_state[g] == BAR_WAIT);
    assign w_wait[g]      = (w_state[g] == BAR_WAIT);
  end

  // Release when every participant waits; slots leave BAR_WAIT on the next edge.
  assign w_bar_rel    = (w_part != '0) && (w_part == w_wait);
  assign bar_release  = w_bar_rel;
  assign all_done     = (active_mask == '0);
  assign err_protocol = r_err;

endmodule

// File: tb/tb_warp_ready_ctrl.sv
// Directed bench for warp_ready_ctrl with hand-computed expectations per scenario.
module tb_warp_ready_ctrl;

  logic       clk, rst;
  logic       launch_valid, launch_ready;
  logic [2:0] launch_id;
  logic [7:0] issue_onehot;
  logic       issue_valid, issue_accept, issue_is_mem, issue_is_bar, issue_is_exit;
  logic       mem_done_valid;
  logic [2:0] mem_done_id;
  logic [7:0] ready_mask, active_mask;
  logic       bar_release, all_done, err_protocol;

  int total = 0;
  int bad   = 0;

  warp_ready_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .launch_valid   (launch_valid),
    .launch_id      (launch_id),
    .launch_ready   (launch_ready),
    .issue_onehot   (issue_onehot),
    .issue_valid    (issue_valid),
    .issue_accept   (issue_accept),
    .issue_is_mem   (issue_is_mem),
    .issue_is_bar   (issue_is_bar),
    .issue_is_exit  (issue_is_exit),
    .mem_done_valid (mem_done_valid),
    .mem_done_id    (mem_done_id),
    .ready_mask     (ready_mask),
    .active_mask    (active_mask),
    .bar_release    (bar_release),
    .all_done       (all_done),
    .err_protocol   (err_protocol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_inputs();
    launch_valid = 0; issue_valid = 0; issue_accept = 0; issue_onehot = '0;
    issue_is_mem = 0; issue_is_bar = 0; issue_is_exit = 0;
    mem_done_valid = 0; mem_done_id = '0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    launch_id = '0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic do_launch(input logic [2:0] id);
    launch_valid = 1; launch_id = id;
    tick();
    launch_valid = 0;
  endtask

  task automatic do_issue(input logic [7:0] oh, input logic m, input logic b, input logic e);
    issue_valid = 1; issue_accept = 1; issue_onehot = oh;
    issue_is_mem = m; issue_is_bar = b; issue_is_exit = e;
    tick();
    issue_valid = 0; issue_accept = 0; issue_onehot = '0;
    issue_is_mem = 0; issue_is_bar = 0; issue_is_exit = 0;
  endtask

  task automatic do_memdone(input logic [2:0] id);
    mem_done_valid = 1; mem_done_id = id;
    tick();
    mem_done_valid = 0;
  endtask

  task automatic test_reset();
    reset_dut();
    total++; if (ready_mask !== 8'h00) begin bad++; $display("FAIL rst_ready got=%h exp=00", ready_mask); end
    total++; if (active_mask !== 8'h00) begin bad++; $display("FAIL rst_active got=%h exp=00", active_mask); end
    total++; if (bar_release !== 1'b0) begin bad++; $display("FAIL rst_bar got=%b exp=0", bar_release); end
    total++; if (all_done !== 1'b1) begin bad++; $display("FAIL rst_all_done got=%b exp=1", all_done); end
    total++; if (err_protocol !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err_protocol); end
    total++; if (launch_ready !== 1'b1) begin bad++; $display("FAIL rst_launch_ready got=%b exp=1", launch_ready); end
  endtask

  task automatic test_launch();
    do_launch(3'd0);
    total++; if (ready_mask !== 8'h01) begin bad++; $display("FAIL launch0_ready got=%h exp=01", ready_mask); end
    do_launch(3'd3);
    total++; if (ready_mask !== 8'h09) begin bad++; $display("FAIL launch3_ready got=%h exp=09", ready_mask); end
    total++; if (active_mask !== 8'h09) begin bad++; $display("FAIL launch_active got=%h exp=09", active_mask); end
    total++; if (all_done !== 1'b0) begin bad++; $display("FAIL launch_all_done got=%b exp=0", all_done); end
    total++; if (launch_ready !== 1'b0) begin bad++; $display("FAIL launch_ready_busy got=%b exp=0", launch_ready); end
  endtask

  task automatic test_alu_cooldown();
    do_issue(8'h01, 0, 0, 0);
    total++; if (ready_mask !== 8'h08) begin bad++; $display("FAIL cool_c1 got=%h exp=08", ready_mask); end
    tick();
    total++; if (ready_mask !== 8'h08) begin bad++; $display("FAIL cool_c2 got=%h exp=08", ready_mask); end
    tick();
    total++; if (ready_mask !== 8'h09) begin bad++; $display("FAIL cool_c3 got=%h exp=09", ready_mask); end
  endtask

  task automatic test_mem();
    for (int i = 0; i < 3; i++) begin
      do_issue(8'h08, 1, 0, 0);
      idle(2);
    end
    total++; if (ready_mask !== 8'h09) begin bad++; $display("FAIL mem_out3 got=%h exp=09", ready_mask); end
    issue_valid = 1; issue_accept = 1; issue_onehot = 8'h08; issue_is_mem = 1;
    mem_done_valid = 1; mem_done_id = 3'd3;
    tick();
    clear_inputs();
    idle(2);
    total++; if (ready_mask !== 8'h09) begin bad++; $display("FAIL mem_same_cycle got=%h exp=09", ready_mask); end
    do_issue(8'h08, 1, 0, 0);
    idle(2);
    total++; if (ready_mask !== 8'h01) begin bad++; $display("FAIL mem_full got=%h exp=01", ready_mask); end
    do_memdone(3'd3);
    total++; if (ready_mask !== 8'h09) begin bad++; $display("FAIL mem_drain_one got=%h exp=09", ready_mask); end
    total++; if (err_protocol !== 1'b0) begin bad++; $display("FAIL mem_err got=%b exp=0", err_protocol); end
  endtask

  task automatic test_barrier();
    do_issue(8'h01, 0, 1, 0);
    total++; if (bar_release !== 1'b0) begin bad++; $display("FAIL bar1_first got=%b exp=0", bar_release); end
    total++; if (ready_mask !== 8'h08) begin bad++; $display("FAIL bar1_ready_a got=%h exp=08", ready_mask); end
    do_issue(8'h08, 0, 1, 0);
    total++; if (bar_release !== 1'b1) begin bad++; $display("FAIL bar1_pulse got=%b exp=1", bar_release); end
    total++; if (ready_mask !== 8'h00) begin bad++; $display("FAIL bar1_ready_b got=%h exp=00", ready_mask); end
    tick();
    total++; if (bar_release !== 1'b0) begin bad++; $display("FAIL bar1_pulse_end got=%b exp=0", bar_release); end
    total++; if (ready_mask !== 8'h01) begin bad++; $display("FAIL bar1_ready_c got=%h exp=01", ready_mask); end
    total++; if (active_mask !== 8'h09) begin bad++; $display("FAIL bar1_active got=%h exp=09", active_mask); end
    tick();
    do_issue(8'h01, 0, 1, 0);
    do_launch(3'd5);
    do_issue(8'h08, 0, 1, 0);
    total++; if (bar_release !== 1'b0) begin bad++; $display("FAIL bar2_blocked got=%b exp=0", bar_release); end
    total++; if (ready_mask !== 8'h20) begin bad++; $display("FAIL bar2_ready_a got=%h exp=20", ready_mask); end
    tick();
    total++; if (bar_release !== 1'b0) begin bad++; $display("FAIL bar2_still got=%b exp=0", bar_release); end
    do_issue(8'h20, 0, 1, 0);
    total++; if (bar_release !== 1'b1) begin bad++; $display("FAIL bar2_pulse got=%b exp=1", bar_release); end
    tick();
    total++; if (bar_release !== 1'b0) begin bad++; $display("FAIL bar2_pulse_end got=%b exp=0", bar_release); end
    total++; if (ready_mask !== 8'h09) begin bad++; $display("FAIL bar2_ready_b got=%h exp=09", ready_mask); end
    total++; if (active_mask !== 8'h29) begin bad++; $display("FAIL bar2_active got=%h exp=29", active_mask); end
  endtask

  task automatic test_exit_drain();
    do_memdone(3'd3);
    do_issue(8'h08, 0, 0, 1);
    total++; if (ready_mask !== 8'h21) begin bad++; $display("FAIL exit_ready got=%h exp=21", ready_mask); end
    total++; if (active_mask !== 8'h29) begin bad++; $display("FAIL exit_drain_active got=%h exp=29", active_mask); end
    do_memdone(3'd3);
    do_memdone(3'd3);
    total++; if (active_mask !== 8'h29) begin bad++; $display("FAIL drain_hold got=%h exp=29", active_mask); end
    tick();
    total++; if (active_mask !== 8'h21) begin bad++; $display("FAIL drain_free got=%h exp=21", active_mask); end
    do_issue(8'h01, 0, 0, 1);
    do_issue(8'h20, 0, 0, 1);
    total++; if (active_mask !== 8'h20) begin bad++; $display("FAIL exit0_free got=%h exp=20", active_mask); end
    total++; if (all_done !== 1'b0) begin bad++; $display("FAIL exit_not_done got=%b exp=0", all_done); end
    tick();
    total++; if (all_done !== 1'b1) begin bad++; $display("FAIL exit_all_done got=%b exp=1", all_done); end
    total++; if (ready_mask !== 8'h00) begin bad++; $display("FAIL exit_ready_end got=%h exp=00", ready_mask); end
    total++; if (err_protocol !== 1'b0) begin bad++; $display("FAIL exit_err got=%b exp=0", err_protocol); end
  endtask

  task automatic test_errors();
    reset_dut();
    do_launch(3'd1);
    do_launch(3'd2);
    issue_valid = 1; issue_accept = 0; issue_onehot = 8'h02; issue_is_bar = 1;
    tick();
    clear_inputs();
    total++; if (err_protocol !== 1'b0) begin bad++; $display("FAIL noaccept_err got=%b exp=0", err_protocol); end
    total++; if (ready_mask !== 8'h06) begin bad++; $display("FAIL noaccept_ready got=%h exp=06", ready_mask); end
    do_issue(8'h06, 0, 0, 0);
    total++; if (err_protocol !== 1'b1) begin bad++; $display("FAIL twohot_err got=%b exp=1", err_protocol); end
    total++; if (ready_mask !== 8'h06) begin bad++; $display("FAIL twohot_ready got=%h exp=06", ready_mask); end
    idle(3);
    total++; if (err_protocol !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err_protocol); end

    reset_dut();
    total++; if (err_protocol !== 1'b0) begin bad++; $display("FAIL err_cleared got=%b exp=0", err_protocol); end
    do_launch(3'd1);
    do_memdone(3'd6);
    total++; if (err_protocol !== 1'b1) begin bad++; $display("FAIL mdfree_err got=%b exp=1", err_protocol); end
    total++; if (active_mask !== 8'h02) begin bad++; $display("FAIL mdfree_active got=%h exp=02", active_mask); end

    reset_dut();
    do_launch(3'd1);
    do_issue(8'h02, 0, 0, 0);
    total++; if (err_protocol !== 1'b0) begin bad++; $display("FAIL legal_issue_err got=%b exp=0", err_protocol); end
    do_issue(8'h02, 0, 1, 0);
    total++; if (err_protocol !== 1'b1) begin bad++; $display("FAIL stalled_err got=%b exp=1", err_protocol); end
    tick();
    total++; if (ready_mask !== 8'h02) begin bad++; $display("FAIL stalled_ready got=%h exp=02", ready_mask); end

    reset_dut();
    do_launch(3'd1);
    do_issue(8'h00, 0, 0, 0);
    total++; if (err_protocol !== 1'b1) begin bad++; $display("FAIL zerohot_err got=%b exp=1", err_protocol); end

    reset_dut();
    do_launch(3'd1);
    do_launch(3'd2);
    do_issue(8'h02, 1, 1, 1);
    total++; if (err_protocol !== 1'b1) begin bad++; $display("FAIL multicls_err got=%b exp=1", err_protocol); end
    total++; if (ready_mask !== 8'h04) begin bad++; $display("FAIL multicls_ready got=%h exp=04", ready_mask); end
    tick();
    total++; if (active_mask !== 8'h04) begin bad++; $display("FAIL multicls_exit got=%h exp=04", active_mask); end
  endtask

  task automatic test_reset_mid_barrier();
    reset_dut();
    do_launch(3'd0);
    do_launch(3'd1);
    do_issue(8'h01, 0, 1, 0);
    do_memdone(3'd5);
    @(posedge clk);
    #3 rst = 1;
    #1;
    total++; if (ready_mask !== 8'h00) begin bad++; $display("FAIL midrst_ready got=%h exp=00", ready_mask); end
    total++; if (active_mask !== 8'h00) begin bad++; $display("FAIL midrst_active got=%h exp=00", active_mask); end
    total++; if (bar_release !== 1'b0) begin bad++; $display("FAIL midrst_bar got=%b exp=0", bar_release); end
    total++; if (all_done !== 1'b1) begin bad++; $display("FAIL midrst_all_done got=%b exp=1", all_done); end
    total++; if (err_protocol !== 1'b0) begin bad++; $display("FAIL midrst_err got=%b exp=0", err_protocol); end
    @(posedge clk);
    #1 rst = 0;
    tick();
    total++; if (active_mask !== 8'h00) begin bad++; $display("FAIL postrst_active got=%h exp=00", active_mask); end
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    launch_id = '0;
    test_reset();
    test_launch();
    test_alu_cooldown();
    test_mem();
    test_barrier();
    test_exit_drain();
    test_errors();
    test_reset_mid_barrier();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
